// File: rtl/uart_rx_ring_pkg.sv
// Shared constants for the UART receive-to-ring block: memory access widths,
// register indices, CFG bit positions and the receiver state encoding.
package uart_rx_ring_pkg;

    localparam logic [1:0] MEM_ACC_8  = 2'b00;
    localparam logic [1:0] MEM_ACC_16 = 2'b01;
    localparam logic [1:0] MEM_ACC_32 = 2'b10;

    localparam logic [2:0] REG_CFG        = 3'd0;
    localparam logic [2:0] REG_DIV        = 3'd1;
    localparam logic [2:0] REG_BUF_START  = 3'd2;
    localparam logic [2:0] REG_BUF_END    = 3'd3;
    localparam logic [2:0] REG_WR_PTR     = 3'd4;
    localparam logic [2:0] REG_RD_PTR     = 3'd5;
    localparam logic [2:0] REG_IRQ_THRESH = 3'd6;

    localparam int CFG_EN         = 0;
    localparam int CFG_PAR_LSB    = 1;
    localparam int CFG_DBITS_LSB  = 4;
    localparam int CFG_IRQ_EN     = 8;
    localparam int CFG_OVERRUN    = 16;
    localparam int CFG_FRAME_ERR  = 17;
    localparam int CFG_PARITY_ERR = 18;
    localparam int CFG_EMPTY      = 19;
    localparam int CFG_FULL       = 20;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ring_baudgen.sv
// Baud tick generator: down-counter reloaded from the divisor, tick while at zero.
// Latency: tick every DIV+1 cycles (every cycle when DIV=0); no backpressure.
module uart_baudgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_ring.sv
// UART receiver writing good bytes into a memory ring through a one-byte hold register.
// Latency: byte stored two cycles after the stop sample; mem_req held until mem_ready, ring full stalls the hold.
module uart_rx_ring
    import uart_rx_ring_pkg::*;
#(
    parameter int M_WIDTH    = 32,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [2:0]         reg_select,
    input  logic [M_WIDTH-1:0] reg_data_in,
    output logic [M_WIDTH-1:0] reg_data_out,
    output logic               reg_ready,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic [M_WIDTH-1:0] mem_addr,
    output logic [1:0]         mem_width,
    output logic [M_WIDTH-1:0] mem_data_out,
    input  logic               rx,
    output logic               irq
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

    logic                 en_q, en_d, irq_en_q, irq_en_d;
    logic [1:0]           par_q, par_d, dbits_q, dbits_d;
    logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [M_WIDTH-1:0]   buf_start_q, buf_start_d, buf_end_q, buf_end_d;
    logic [M_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, thresh_q, thresh_d;
    logic [M_WIDTH-1:0]   rdata_q, rdata_d, addr_q, addr_d;
    logic                 rready_q, irq_q, irq_d, req_q, req_d;
    logic                 rx_s1_q, rx_s2_q;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]           bcnt_q, bcnt_d;
    logic [7:0]           shift_q, shift_d, hold_dat_q, hold_dat_d;
    logic                 bad_q, bad_d, hold_vld_q, hold_vld_d;

    logic               tick, rx_good, rx_ferr, rx_perr;
    logic               wr_en, accept, hold_busy, ring_ok, full, empty;
    logic [M_WIDTH-1:0] wr_inc, wr_next, ring_size, count, cfg_rd;
    logic [2:0]         last_bit;

    uart_baudgen #(.DIV_WIDTH(DIV_WIDTH)) u_baudgen (
        .clk    (clk),
        .rst    (rst),
        .div_i  (div_q),
        .tick_o (tick)
    );

    assign last_bit = {1'b0, dbits_q} + 3'd4;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        rx_good = 1'b0;
        rx_ferr = 1'b0;
        rx_perr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q && !rx_s2_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    shift_d = '0;
                    bad_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d  = '0;
                        state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d          = '0;
                        shift_d[bcnt_q] = rx_s2_q;
                        bcnt_d          = bcnt_q + 3'd1;
                        if (bcnt_q == last_bit) begin
                            state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        state_d = ST_STOP;
                        // Data bits above the frame width are zero, so a full-byte XOR is exact.
                        if ((^shift_q ^ rx_s2_q) != (par_q == PAR_ODD)) begin
                            bad_d   = 1'b1;
                            rx_perr = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        state_d = ST_IDLE;
                        if (!rx_s2_q) begin
                            rx_ferr = 1'b1;
                        end else if (!bad_q) begin
                            rx_good = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en_q) begin
            state_d = ST_IDLE;
        end
    end

    // A zero-size ring (END <= START, e.g. after reset) accepts nothing and reports neither full nor empty.
    assign ring_ok   = (buf_end_q > buf_start_q);
    assign wr_inc    = wr_ptr_q + 1'b1;
    assign wr_next   = (wr_inc == buf_end_q) ? buf_start_q : wr_inc;
    assign full      = ring_ok && (wr_next == rd_ptr_q);
    assign empty     = ring_ok && (wr_ptr_q == rd_ptr_q);
    assign ring_size = buf_end_q - buf_start_q;
    assign count     = (wr_ptr_q >= rd_ptr_q) ? (wr_ptr_q - rd_ptr_q)
                                              : (wr_ptr_q - rd_ptr_q + ring_size);
    assign accept    = req_q && mem_ready;
    assign hold_busy = hold_vld_q && !accept;
    assign wr_en     = reg_req && reg_we;

    always_comb begin
        cfg_rd                         = '0;
        cfg_rd[CFG_EN]                 = en_q;
        cfg_rd[CFG_PAR_LSB +: 2]       = par_q;
        cfg_rd[CFG_DBITS_LSB +: 2]     = dbits_q;
        cfg_rd[CFG_IRQ_EN]             = irq_en_q;
        cfg_rd[CFG_OVERRUN]            = ovr_q;
        cfg_rd[CFG_FRAME_ERR]          = ferr_q;
        cfg_rd[CFG_PARITY_ERR]         = perr_q;
        cfg_rd[CFG_EMPTY]              = empty;
        cfg_rd[CFG_FULL]               = full;
    end

    always_comb begin
        en_d        = en_q;
        par_d       = par_q;
        dbits_d     = dbits_q;
        irq_en_d    = irq_en_q;
        div_d       = div_q;
        buf_start_d = buf_start_q;
        buf_end_d   = buf_end_q;
        thresh_d    = thresh_q;
        wr_ptr_d    = accept ? wr_next : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovr_d       = ovr_q;
        ferr_d      = ferr_q;
        perr_d      = perr_q;
        if (wr_en) begin
            case (reg_select)
                REG_CFG: begin
                    en_d     = reg_data_in[CFG_EN];
                    par_d    = reg_data_in[CFG_PAR_LSB +: 2];
                    dbits_d  = reg_data_in[CFG_DBITS_LSB +: 2];
                    irq_en_d = reg_data_in[CFG_IRQ_EN];
                    ovr_d    = ovr_q  & ~reg_data_in[CFG_OVERRUN];
                    ferr_d   = ferr_q & ~reg_data_in[CFG_FRAME_ERR];
                    perr_d   = perr_q & ~reg_data_in[CFG_PARITY_ERR];
                end
                REG_DIV:        div_d     = reg_data_in[DIV_WIDTH-1:0];
                REG_BUF_START: begin
                    buf_start_d = reg_data_in;
                    wr_ptr_d    = reg_data_in;
                    rd_ptr_d    = reg_data_in;
                end
                REG_BUF_END:    buf_end_d = reg_data_in;
                REG_RD_PTR:     rd_ptr_d  = reg_data_in;
                REG_IRQ_THRESH: thresh_d  = reg_data_in;
                default: ;
            endcase
        end
        // Hardware set is applied after the W1C clear so a simultaneous event is never lost.
        ovr_d  = ovr_d  | (rx_good && hold_busy);
        ferr_d = ferr_d | rx_ferr;
        perr_d = perr_d | rx_perr;

        hold_dat_d = hold_dat_q;
        hold_vld_d = hold_vld_q && !accept;
        if (rx_good && !hold_busy) begin
            hold_vld_d = 1'b1;
            hold_dat_d = shift_q;
        end

        req_d  = req_q && !accept;
        addr_d = addr_q;
        if (!req_q && hold_vld_q && ring_ok && !full) begin
            req_d  = 1'b1;
            addr_d = wr_ptr_q;
        end

        case (reg_select)
            REG_CFG:        rdata_d = cfg_rd;
            REG_DIV:        rdata_d = M_WIDTH'(div_q);
            REG_BUF_START:  rdata_d = buf_start_q;
            REG_BUF_END:    rdata_d = buf_end_q;
            REG_WR_PTR:     rdata_d = wr_ptr_q;
            REG_RD_PTR:     rdata_d = rd_ptr_q;
            REG_IRQ_THRESH: rdata_d = thresh_q;
            default:        rdata_d = '0;
        endcase
        if (!reg_req) begin
            rdata_d = rdata_q;
        end

        irq_d = irq_en_q && (((thresh_q != '0) && (count >= thresh_q)) || ovr_q || ferr_q || perr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            par_q       <= '0;
            dbits_q     <= '0;
            irq_en_q    <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            div_q       <= '0;
            buf_start_q <= '0;
            buf_end_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            thresh_q    <= '0;
            rdata_q     <= '0;
            rready_q    <= 1'b0;
            irq_q       <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            // Synchronizer resets to the idle line level so no start bit is seen on release.
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            bad_q       <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= '0;
        end else begin
            en_q        <= en_d;
            par_q       <= par_d;
            dbits_q     <= dbits_d;
            irq_en_q    <= irq_en_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            div_q       <= div_d;
            buf_start_q <= buf_start_d;
            buf_end_q   <= buf_end_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            thresh_q    <= thresh_d;
            rdata_q     <= rdata_d;
            rready_q    <= reg_req;
            irq_q       <= irq_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            bad_q       <= bad_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
        end
    end

    assign reg_data_out = rdata_q;
    assign reg_ready    = rready_q;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign mem_width    = MEM_ACC_8;
    assign mem_data_out = {{(M_WIDTH-8){1'b0}}, hold_dat_q};
    assign irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_ring.sv
// Directed bench for uart_rx_ring: register setup, serial frames, ring writes, errors and reset.
module tb_uart_rx_ring;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_req = 1'b0;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_select = 3'd0;
    logic [31:0] reg_data_in = 32'd0;
    logic [31:0] reg_data_out;
    logic        reg_ready;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic [31:0] mem_data_out;
    logic        rx = 1'b1;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int bit_cyc = 432;
    logic [31:0] v;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always #5 clk = ~clk;

    uart_rx_ring #(.M_WIDTH(32), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_select   (reg_select),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .reg_ready    (reg_ready),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_width    (mem_width),
        .mem_data_out (mem_data_out),
        .rx           (rx),
        .irq          (irq)
    );

    // mem_ready only changes just after a posedge, so the negedge view matches what the next edge accepts.
    always @(negedge clk) begin
        if (rst && mem_req && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] sel, input logic [31:0] data);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_select = sel; reg_data_in = data;
        @(negedge clk);
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] sel, output logic [31:0] data);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b0; reg_select = sel;
        @(negedge clk);
        reg_req = 1'b0;
        data = reg_data_out;
    endtask

    task automatic set_ready(input logic val);
        @(posedge clk);
        #1 mem_ready = val;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par,
                              input logic pbit, input logic stopb);
        @(negedge clk);
        rx = 1'b0;
        repeat (bit_cyc) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (bit_cyc) @(negedge clk);
        end
        if (has_par) begin
            rx = pbit;
            repeat (bit_cyc) @(negedge clk);
        end
        rx = stopb;
        if (stopb) begin
            repeat (bit_cyc) @(negedge clk);
        end else begin
            // Low long enough to cover the mid-bit sample, then release so no new start is seen.
            repeat (bit_cyc * 5 / 8) @(negedge clk);
            rx = 1'b1;
            repeat (bit_cyc - bit_cyc * 5 / 8) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * bit_cyc) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_reg_ready", 32'(reg_ready), 32'd0);
        check("rst_reg_data_out", reg_data_out, 32'd0);
        rst = 1'b1;
        reg_rd(3'd0, v);
        check("cfg_after_reset", v, 32'd0);

        // 8N1, DIV=26, ring 0x100-0x110, byte 0xA5 with the store held off
        reg_wr(3'd1, 32'd26);
        reg_wr(3'd2, 32'h100);
        reg_wr(3'd3, 32'h110);
        reg_wr(3'd0, 32'h31);
        reg_rd(3'd0, v);
        check("cfg_8n1_empty", v, 32'h0008_0031);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("a5_req", 32'(mem_req), 32'd1);
        check("a5_addr", mem_addr, 32'h100);
        check("a5_data", mem_data_out, 32'h0000_00A5);
        check("a5_width", 32'(mem_width), 32'd0);
        repeat (5) @(negedge clk);
        check("a5_req_held", 32'(mem_req), 32'd1);
        check("a5_addr_held", mem_addr, 32'h100);
        set_ready(1'b1);
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            @(negedge clk);
        end
        check("a5_req_release", 32'(mem_req), 32'd0);
        check("a5_one_write", 32'(log_addr.size()), 32'd1);
        reg_rd(3'd4, v);
        check("a5_wr_ptr", v, 32'h101);

        // Small ring 0x100-0x104: fill, hold, overrun, then release by moving RD_PTR
        bit_cyc = 64;
        reg_wr(3'd1, 32'd3);
        reg_wr(3'd2, 32'h100);
        reg_wr(3'd3, 32'h104);
        repeat (40) @(negedge clk);
        log_addr.delete();
        log_data.delete();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
        check("fill_writes", 32'(log_addr.size()), 32'd3);
        check("fill_addr0", log_addr[0], 32'h100);
        check("fill_addr2", log_addr[2], 32'h102);
        check("fill_data1", log_data[1], 32'h22);
        reg_rd(3'd0, v);
        check("cfg_full", v, 32'h0010_0031);
        reg_rd(3'd4, v);
        check("full_wr_ptr", v, 32'h103);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1);
        check("held_no_req", 32'(mem_req), 32'd0);
        check("held_no_write", 32'(log_addr.size()), 32'd3);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        reg_rd(3'd0, v);
        check("cfg_overrun", v, 32'h0011_0031);
        check("irq_masked", 32'(irq), 32'd0);
        reg_wr(3'd5, 32'h101);
        repeat (6) @(negedge clk);
        check("release_writes", 32'(log_addr.size()), 32'd4);
        check("release_addr", log_addr[3], 32'h103);
        check("release_data", log_data[3], 32'h44);
        reg_rd(3'd4, v);
        check("wrap_wr_ptr", v, 32'h100);
        reg_wr(3'd0, 32'h0001_0031);
        reg_rd(3'd0, v);
        check("overrun_w1c", v, 32'h0010_0031);

        // 7 data bits, even parity, irq enabled
        reg_wr(3'd2, 32'h200);
        reg_wr(3'd3, 32'h210);
        reg_wr(3'd0, 32'h0007_0123);
        log_addr.delete();
        log_data.delete();
        repeat (3) @(negedge clk);
        check("par_irq_idle", 32'(irq), 32'd0);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
        reg_rd(3'd0, v);
        check("cfg_parity_err", v, 32'h000C_0123);
        check("par_no_req", 32'(mem_req), 32'd0);
        check("par_no_write", 32'(log_addr.size()), 32'd0);
        check("par_irq", 32'(irq), 32'd1);
        reg_wr(3'd0, 32'h0004_0123);
        repeat (3) @(negedge clk);
        check("par_irq_cleared", 32'(irq), 32'd0);
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
        check("par_good_write", 32'(log_addr.size()), 32'd1);
        check("par_good_addr", log_addr[0], 32'h200);
        check("par_good_data", log_data[0], 32'h55);
        check("thresh0_irq", 32'(irq), 32'd0);
        reg_wr(3'd6, 32'd1);
        repeat (3) @(negedge clk);
        check("thresh1_irq", 32'(irq), 32'd1);
        reg_wr(3'd6, 32'd2);
        repeat (3) @(negedge clk);
        check("thresh2_irq", 32'(irq), 32'd0);

        // False start, then a good byte, then a low stop bit
        reg_wr(3'd0, 32'h131);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (3 * bit_cyc) @(negedge clk);
        check("false_start_no_req", 32'(mem_req), 32'd0);
        check("false_start_no_write", 32'(log_addr.size()), 32'd1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        check("after_false_write", 32'(log_addr.size()), 32'd2);
        check("after_false_addr", log_addr[1], 32'h201);
        check("after_false_data", log_data[1], 32'h3C);
        check("count_thresh_irq", 32'(irq), 32'd1);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0);
        reg_rd(3'd0, v);
        check("cfg_frame_err", v, 32'h0002_0131);
        check("frame_err_no_write", 32'(log_addr.size()), 32'd2);

        // Reset pulse mid-frame with a store pending and a register access completing
        set_ready(1'b0);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
        check("pend_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rx = 1'b0;
        repeat (bit_cyc * 5 / 2) @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b0; reg_select = 3'd0;
        @(negedge clk);
        reg_req = 1'b0;
        check("pre_rst_ready", 32'(reg_ready), 32'd1);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_ready", 32'(reg_ready), 32'd0);
        check("async_rst_rdata", reg_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        reg_rd(3'd0, v);
        check("cfg_after_pulse", v, 32'd0);
        reg_rd(3'd4, v);
        check("wr_ptr_after_pulse", v, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ring.md
UART_RX_RING -- requirements
Module: uart_rx_ring

Interface
REQ-001 M_WIDTH, 32, register and memory bus width.
REQ-002 OVERSAMPLE, 16, baud ticks per bit; even, >=4.
REQ-003 DIV_WIDTH, 16, width of baud divisor register.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 reg_req  input  1  register access strobe.
REQ-007 reg_we  input  1  write qualifier for reg_req.
REQ-008 reg_select  input  3  register index.
REQ-009 reg_data_in  input  M_WIDTH  write data.
REQ-010 reg_data_out  output  M_WIDTH  read data, registered.
REQ-011 reg_ready  output  1  access complete.
REQ-012 mem_ready  input  1  memory write accepted.
REQ-013 mem_req  output  1  memory write request.
REQ-014 mem_addr  output  M_WIDTH  byte address.
REQ-015 mem_width  output  2  always MEM_ACC_8 (2'b00).
REQ-016 mem_data_out  output  M_WIDTH  received byte, zero-extended.
REQ-017 rx  input  1  serial line, asynchronous, idle high.
REQ-018 irq  output  1  level interrupt, registered.

Function
REQ-019 Registers: 0 CFG, 1 DIV, 2 BUF_START, 3 BUF_END (exclusive), 4 WR_PTR (RO), 5 RD_PTR, 6 IRQ_THRESH, 7 reads 0.
REQ-020 CFG: bit0 en; [2:1] parity 00 none/01 even/10 odd; [5:4] data bits 5+value; bit8 irq_en; status RO: bit19 empty, bit20 full; W1C: bit16 overrun, bit17 frame_err, bit18 parity_err.
REQ-021 reg_ready = reg_req delayed one cycle; reg_data_out loads the selected register on the same edge.
REQ-022 Writing BUF_START sets WR_PTR and RD_PTR to the new value.
REQ-023 rx passes a 2-flop synchronizer before use.
REQ-024 Baud tick: counter reloads DIV, pulses one cycle on reaching 0; DIV=0 ticks every cycle.
REQ-025 FSM: IDLE, START, DATA, PARITY, STOP; leaves IDLE on en and synchronized rx low.
REQ-026 START samples at OVERSAMPLE/2 ticks; high sample means false start -> IDLE.
REQ-027 DATA samples LSB first every OVERSAMPLE ticks; PARITY is skipped when parity=00.
REQ-028 Parity mismatch sets parity_err and drops the byte; low stop sample sets frame_err and drops the byte.
REQ-029 Good byte at STOP loads the one-byte hold register; a hold register still occupied sets overrun and drops the new byte.
REQ-030 Store: hold register valid and ring not full -> mem_req=1, mem_addr=WR_PTR, held stable until mem_ready.
REQ-031 On accept, WR_PTR+1; wraps to BUF_START when equal to BUF_END; hold register cleared.
REQ-032 Full when next(WR_PTR)==RD_PTR; capacity BUF_END-BUF_START-1. Empty when WR_PTR==RD_PTR.
REQ-033 Full with hold register valid: no request; next completed byte sets overrun.
REQ-034 Same-cycle RD_PTR write and WR_PTR advance both take effect; full/empty are recomputed from the new values.
REQ-035 count=(WR_PTR-RD_PTR) mod ring size; irq = irq_en & ((THRESH!=0 & count>=THRESH) | any error flag).
REQ-036 Clearing en mid-frame returns the FSM to IDLE at the next edge; a pending mem_req completes.
REQ-037 Same-cycle error set and W1C clear: set wins.

Reset
REQ-038 rst low clears immediately: outputs 0, registers 0, FSM IDLE, hold register empty, baud counter 0.

Structure
REQ-039 A shared package holds MEM_ACC_8/16/32, register indices and CFG bit positions.
REQ-040 Sub-module uart_baudgen holds the divisor counter and tick output.

Verification
REQ-041 8N1 frame, DIV=26, OVERSAMPLE=16, BUF 0x100-0x110, byte 0xA5 -> one write: addr 0x100, data 0x000000A5, width 00; WR_PTR 0x101.
REQ-042 BUF 0x100-0x104, RD 0x100, 4 bytes -> 3 writes, full=1; 4th byte held, 5th byte sets overrun; RD_PTR write 0x101 -> held byte written at 0x103; WR_PTR wraps to 0x100.
REQ-043 7 data bits, even parity, 0x55 with parity bit 1 -> parity_err=1, no mem_req, irq=1 if irq_en.
REQ-044 rx low for 4 ticks only -> false start, FSM IDLE, no write; stop bit low -> frame_err=1.
REQ-045 rst low for 1 cycle during DATA with mem_req high -> mem_req, irq and reg_ready low immediately; CFG reads 0.
